// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton conditioner: state encoding,
// counter width and default timing parameters.
// No logic; imported by button_conditioner.
package button_pkg;

    localparam int CNT_W               = 16;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int LONG_CYCLES_DEF     = 16;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] ST_PRESSED      = 3'd2;
    localparam logic [2:0] ST_LONG_HELD    = 3'd3;
    localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE         = ST_IDLE,
        S_PRESS_WAIT   = ST_PRESS_WAIT,
        S_PRESSED      = ST_PRESSED,
        S_LONG_HELD    = ST_LONG_HELD,
        S_RELEASE_WAIT = ST_RELEASE_WAIT
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 clk edges from d to q.
// No backpressure; both flops clear immediately on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Shift the raw level through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw pushbutton into a clean level plus press/release/long-press pulses.
// Latency: b_press follows a steady high input by DEBOUNCE_CYCLES+2 edges (2 sync + debounce).
// No backpressure; pulses are single-cycle and mutually exclusive.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       b_raw,
    output logic       b_level,
    output logic       b_press,
    output logic       b_release,
    output logic       b_long,
    output logic [7:0] press_cnt
);

    // Terminal values in counter width; the hold counter is compared one
    // below its terminal so the increment never needs an extra bit.
    localparam logic [CNT_W-1:0] DB_TERM      = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LONG_TERM    = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_TERM_M1 = CNT_W'(LONG_CYCLES - 1);

    logic             w_b_s;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] w_db_cnt_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic             r_ret_long;
    logic             w_ret_long_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;
    logic             r_long;
    logic             w_long_nxt;
    logic [7:0]       r_press_cnt;
    logic [7:0]       w_press_cnt_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (b_raw),
        .q     (w_b_s)
    );

    // State, counters and registered event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_ret_long  <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_db_cnt    <= w_db_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_ret_long  <= w_ret_long_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_long      <= w_long_nxt;
            r_press_cnt <= w_press_cnt_nxt;
        end
    end

    // Next-state, counter and pulse decisions from the synchronized level.
    always_comb begin
        w_state_nxt     = r_state;
        w_db_cnt_nxt    = r_db_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_ret_long_nxt  = r_ret_long;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_long_nxt      = 1'b0;
        w_press_cnt_nxt = r_press_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_b_s) begin
                    w_state_nxt  = S_PRESS_WAIT;
                    w_db_cnt_nxt = CNT_W'(1);
                end else begin
                    w_db_cnt_nxt = '0;
                end
            end

            S_PRESS_WAIT: begin
                if (!w_b_s) begin
                    w_state_nxt  = S_IDLE;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_TERM) begin
                    w_state_nxt     = S_PRESSED;
                    w_db_cnt_nxt    = '0;
                    w_hold_cnt_nxt  = '0;
                    w_press_nxt     = 1'b1;
                    w_press_cnt_nxt = r_press_cnt + 8'd1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + CNT_W'(1);
                end
            end

            S_PRESSED: begin
                if (!w_b_s) begin
                    w_state_nxt    = S_RELEASE_WAIT;
                    w_db_cnt_nxt   = CNT_W'(1);
                    w_ret_long_nxt = 1'b0;
                end else if (r_hold_cnt == LONG_TERM_M1) begin
                    w_state_nxt    = S_LONG_HELD;
                    w_hold_cnt_nxt = LONG_TERM;
                    w_long_nxt     = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
            end

            S_LONG_HELD: begin
                // Long event already issued; hold counter stays at its terminal.
                if (!w_b_s) begin
                    w_state_nxt    = S_RELEASE_WAIT;
                    w_db_cnt_nxt   = CNT_W'(1);
                    w_ret_long_nxt = 1'b1;
                end
            end

            S_RELEASE_WAIT: begin
                if (w_b_s) begin
                    // Release glitch: resume where we left off, hold count frozen.
                    w_state_nxt  = r_ret_long ? S_LONG_HELD : S_PRESSED;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_TERM) begin
                    w_state_nxt    = S_IDLE;
                    w_db_cnt_nxt   = '0;
                    w_hold_cnt_nxt = '0;
                    w_release_nxt  = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt    = S_IDLE;
                w_db_cnt_nxt   = '0;
                w_hold_cnt_nxt = '0;
            end
        endcase
    end

    assign b_level   = (r_state == S_PRESSED) || (r_state == S_LONG_HELD) ||
                       (r_state == S_RELEASE_WAIT);
    assign b_press   = r_press;
    assign b_release = r_release;
    assign b_long    = r_long;
    assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
// Reference model works on run lengths of the synchronized input, not on FSM states.
// Directed scenarios plus randomized bouncing segments, all compared every cycle.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 16;

    logic       clk;
    logic       rst_n;
    logic       b_raw;
    logic       b_level;
    logic       b_press;
    logic       b_release;
    logic       b_long;
    logic [7:0] press_cnt;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .b_raw     (b_raw),
        .b_level   (b_level),
        .b_press   (b_press),
        .b_release (b_release),
        .b_long    (b_long),
        .press_cnt (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state.
    int m_h0, m_h1;          // two-sample delay of the raw input
    int m_level;             // accepted level
    int m_run_hi, m_run_lo;  // consecutive high / low samples while level 0 / 1
    int m_prev;              // previous synchronized sample
    int m_hold;              // high-after-high samples since the press was accepted
    int m_long_done;
    int m_cnt;
    int m_press, m_release, m_long;

    // Event bookkeeping for directed checks.
    int cyc = 0;
    int base = 0;
    int first_press, first_release, first_long;
    int ev_press, ev_release, ev_long;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_h0 = 0; m_h1 = 0; m_level = 0; m_run_hi = 0; m_run_lo = 0;
        m_prev = 0; m_hold = 0; m_long_done = 0; m_cnt = 0;
        m_press = 0; m_release = 0; m_long = 0;
    endtask

    // A press is accepted on the (D+1)-th consecutive high sample while released,
    // a release on the (D+1)-th consecutive low sample while pressed. Long fires
    // once when L high samples, each preceded by a high sample, follow the press.
    task automatic model_step(input int raw);
        int s;
        s = m_h1;
        m_h1 = m_h0;
        m_h0 = raw;
        m_press = 0; m_release = 0; m_long = 0;
        if (m_level == 0) begin
            m_run_hi = s ? m_run_hi + 1 : 0;
            if (m_run_hi == D + 1) begin
                m_level = 1; m_press = 1; m_cnt = (m_cnt + 1) % 256;
                m_hold = 0; m_long_done = 0; m_run_lo = 0;
            end
        end else begin
            if (s) begin
                m_run_lo = 0;
                if (m_prev && !m_long_done) begin
                    m_hold++;
                    if (m_hold == L) begin
                        m_long = 1; m_long_done = 1;
                    end
                end
            end else begin
                m_run_lo++;
                if (m_run_lo == D + 1) begin
                    m_level = 0; m_release = 1; m_run_hi = 0;
                end
            end
        end
        m_prev = s;
    endtask

    task automatic check_all();
        check_eq("b_level", int'(b_level), m_level);
        check_eq("b_press", int'(b_press), m_press);
        check_eq("b_release", int'(b_release), m_release);
        check_eq("b_long", int'(b_long), m_long);
        check_eq("press_cnt", int'(press_cnt), m_cnt);
        check_eq("pulse_excl", int'(b_press) + int'(b_release) + int'(b_long) <= 1, 1);
    endtask

    task automatic drive(input logic raw);
        b_raw = raw;
        @(posedge clk);
        #1;
        model_step(int'(raw));
        check_all();
        if (b_press) begin
            ev_press++;
            if (first_press < 0) first_press = cyc - base;
        end
        if (b_release) begin
            ev_release++;
            if (first_release < 0) first_release = cyc - base;
        end
        if (b_long) begin
            ev_long++;
            if (first_long < 0) first_long = cyc - base;
        end
        cyc++;
    endtask

    task automatic mark();
        base = cyc;
        first_press = -1; first_release = -1; first_long = -1;
        ev_press = 0; ev_release = 0; ev_long = 0;
    endtask

    task automatic reset_outputs_zero(input string tag);
        check_eq({tag, "_level"}, int'(b_level), 0);
        check_eq({tag, "_pulses"}, int'(b_press) + int'(b_release) + int'(b_long), 0);
        check_eq({tag, "_cnt"}, int'(press_cnt), 0);
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        reset_outputs_zero("rst_now");
        repeat (n) begin
            @(posedge clk);
            #1;
            reset_outputs_zero("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int lvl;
        int len;
        int cnt_before;

        rst_n = 1'b0;
        b_raw = 1'b0;
        model_reset();
        apply_reset(2);

        // Clean press held 30 cycles.
        mark();
        repeat (30) drive(1'b1);
        check_eq("clean_press_edge", first_press, D + 2);
        check_eq("clean_long_edge", first_long, D + 2 + L);
        check_eq("clean_press_evts", ev_press, 1);
        check_eq("clean_long_evts", ev_long, 1);
        check_eq("clean_press_cnt", int'(press_cnt), 1);
        repeat (10) drive(1'b0);
        check_eq("clean_release_evts", ev_release, 1);

        // Bounce too short to be accepted.
        mark();
        cnt_before = m_cnt;
        drive(1'b1); drive(1'b0); drive(1'b1); drive(1'b1); drive(1'b0);
        repeat (10) drive(1'b0);
        check_eq("bounce_press_evts", ev_press, 0);
        check_eq("bounce_cnt", int'(press_cnt), cnt_before);

        // Release glitch while pressed.
        mark();
        repeat (10) drive(1'b1);
        repeat (2) drive(1'b0);
        repeat (6) drive(1'b1);
        check_eq("glitch_level", int'(b_level), 1);
        check_eq("glitch_press_evts", ev_press, 1);
        check_eq("glitch_release_evts", ev_release, 0);
        repeat (10) drive(1'b0);

        // Short press: 8 cycles high then release.
        mark();
        repeat (8) drive(1'b1);
        base = cyc;
        first_release = -1;
        repeat (10) drive(1'b0);
        check_eq("short_release_edge", first_release, D + 2);
        check_eq("short_press_evts", ev_press, 1);
        check_eq("short_long_evts", ev_long, 0);

        // Randomized bouncing segments.
        lvl = 0;
        for (int seg = 0; seg < 120; seg++) begin
            lvl = 1 - lvl;
            if ($urandom_range(0, 3) == 0) len = int'($urandom_range(15, 30));
            else len = int'($urandom_range(1, 7));
            for (int k = 0; k < len; k++) drive(lvl[0]);
        end
        repeat (10) drive(1'b0);

        // Reset while in the long-held phase with the button still down.
        mark();
        repeat (25) drive(1'b1);
        check_eq("midrst_long_evts", ev_long, 1);
        b_raw = 1'b1;
        apply_reset(3);
        mark();
        repeat (10) drive(1'b1);
        check_eq("midrst_press_edge", first_press, D + 2);
        check_eq("midrst_release_evts", ev_release, 0);
        check_eq("midrst_cnt", int'(press_cnt), 1);
        repeat (10) drive(1'b0);

        // 256 clean presses wrap the counter.
        apply_reset(2);
        mark();
        for (int p = 0; p < 256; p++) begin
            repeat (7) drive(1'b1);
            repeat (8) drive(1'b0);
        end
        check_eq("wrap_press_evts", ev_press, 256);
        check_eq("wrap_release_evts", ev_release, 256);
        check_eq("wrap_cnt", int'(press_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized samples needed to accept a level change (legal 1..65535).
REQ-002 SHALL have parameter LONG_CYCLES, default 16: cycles held in PRESSED before a long-press event (legal 1..65535).
REQ-003 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port b_raw, input, 1: raw asynchronous pushbutton (active-high, bouncing).
REQ-006 SHALL have port b_level, output, 1: debounced button level.
REQ-007 SHALL have port b_press, output, 1: one-cycle pulse on accepted press; drives the street-light controller's b input.
REQ-008 SHALL have port b_release, output, 1: one-cycle pulse on accepted release.
REQ-009 SHALL have port b_long, output, 1: one-cycle pulse when a press reaches LONG_CYCLES.
REQ-010 SHALL have port press_cnt, output, 8: count of accepted presses.

Function
REQ-011 SHALL pass b_raw through a 2-flop synchronizer to produce b_s; the FSM uses only b_s.
REQ-012 SHALL implement states IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT.
REQ-013 IDLE: b_s=1 -> PRESS_WAIT with debounce counter=1; else stay.
REQ-014 PRESS_WAIT: b_s=0 -> IDLE, counter cleared, no output event; b_s=1 with counter=DEBOUNCE_CYCLES -> PRESSED; otherwise counter+1.
REQ-015 Entry to PRESSED SHALL set b_press=1 for exactly one cycle, b_level=1, hold counter=0, press_cnt+1.
REQ-016 Latency: b_raw high from before edge 0 -> b_press high in the cycle after edge DEBOUNCE_CYCLES+2.
REQ-017 PRESSED: hold counter+1 per cycle while b_s=1; on reaching LONG_CYCLES -> LONG_HELD with b_long=1 for one cycle.
REQ-018 LONG_HELD: no further b_long until a full release/press sequence completes.
REQ-019 PRESSED or LONG_HELD with b_s=0 -> RELEASE_WAIT, debounce counter=1, return-state flag recorded.
REQ-020 RELEASE_WAIT: b_s=1 -> recorded state; hold counter resumes from its frozen value; no pulse; b_s=0 with counter=DEBOUNCE_CYCLES -> IDLE with b_release=1 for one cycle and b_level=0; otherwise counter+1.
REQ-021 b_level SHALL be 1 in PRESSED, LONG_HELD and RELEASE_WAIT, else 0.
REQ-022 press_cnt SHALL wrap 255 -> 0 without any flag.
REQ-023 Counters SHALL be 16 bit and never exceed their terminal values.
REQ-024 At most one of b_press, b_release, b_long SHALL be high in any cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, both synchronizer flops, all counters, press_cnt and all outputs to 0.
REQ-026 Reset asserted mid-press SHALL produce no b_release; after deassertion with b_raw held high, a fresh b_press SHALL follow per REQ-016.

Structure
REQ-027 Package button_pkg SHALL hold the state encoding (3-bit localparams), counter width (16) and default parameter values.
REQ-028 The synchronizer SHALL be sub-module sync_2ff (clk, rst_n, d, q); the FSM and counters stay in button_conditioner.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-029 Clean press: b_raw 0->1 held 30 cycles -> one b_press after edge 6, press_cnt=1, one b_long 16 cycles after PRESSED entry.
REQ-030 Bounce: b_raw 1,0,1,1,0 per cycle then 0 -> no pulses, b_level stays 0, press_cnt=0.
REQ-031 Release glitch: in PRESSED, b_raw 0 for 2 cycles then 1 -> b_level stays 1, no b_release, no second b_press.
REQ-032 Short press: held 8 cycles then released -> b_press, then b_release 6 cycles after fall, no b_long.
REQ-033 Wrap: 256 clean presses -> press_cnt back to 0, 256 b_press pulses counted.
REQ-034 Reset mid-press: rst_n low 3 cycles during LONG_HELD with b_raw high -> all outputs 0 at once, no b_release; b_press recurs 6 edges after rst_n release.
